// File: rtl/sram_stream_adapter.sv
// -----------------------------------------------------------------------------
// sram_stream_adapter
//
// Front-end for a single-port, byte-enable SRAM macro with a fixed 1-cycle
// read latency and no backpressure. Requests arrive on a valid/ready stream
// and go straight to the SRAM pins. Read data returns on a valid/ready
// response stream through a small FIFO. The request side is throttled by a
// credit check, so read data that the SRAM returns always has a free FIFO
// slot, even while the consumer stalls. Responses keep request order.
//
// Integration: tie the SRAM's rst_ni to ~rst_i.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous, active-high reset
//   req_valid_i   request valid
//   req_ready_o   request accepted when req_valid_i & req_ready_o
//   req_we_i      1 = write, 0 = read
//   req_addr_i    word address
//   req_wdata_i   write data
//   req_be_i      byte enables
//   rsp_valid_o   read response valid
//   rsp_ready_i   consumer ready
//   rsp_rdata_o   read data at the FIFO head
//   sram_req_o    SRAM req_i
//   sram_we_o     SRAM we_i
//   sram_addr_o   SRAM addr_i
//   sram_wdata_o  SRAM wdata_i
//   sram_be_o     SRAM be_i
//   sram_rdata_i  SRAM rdata_o
// -----------------------------------------------------------------------------
module sram_stream_adapter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RSP_DEPTH  = 2,
  localparam int unsigned AW        = $clog2(NUM_WORDS),
  localparam int unsigned NB        = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // Request stream
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NB-1:0]         req_be_i,
  // Response stream
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  // SRAM macro
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [NB-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  // Pointer, occupancy and credit widths. The credit sum (count + inflight)
  // gets one extra bit so it can never wrap before the compare.
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned UW = CW + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  inflight_q, inflight_d;  // read issued last cycle
  logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]         count_q,    count_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

  logic          push;
  logic          pop;
  logic          acc;
  logic [UW-1:0] used;

  // Modulo increment; RSP_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  // Valid is masked during reset so a stale FIFO entry is never offered
  // in the reset cycle itself.
  assign rsp_valid_o = ~rst_i & (count_q != '0);
  assign rsp_rdata_o = mem_q[rd_ptr_q];
  assign pop         = rsp_valid_o & rsp_ready_i;

  // The SRAM has no backpressure: whatever was read last cycle lands now.
  assign push        = inflight_q;

  // ---------------------------------------------------------------------------
  // Request side: credit check
  // ---------------------------------------------------------------------------
  // A slot is owed to every buffered entry and to the read in flight. A pop
  // this cycle frees one, which is why ready looks at rsp_ready_i. Writes are
  // gated the same way, so ready never depends on req_we_i.
  assign used        = UW'(count_q) + UW'(inflight_q) - UW'(pop);
  assign req_ready_o = ~rst_i & (used < UW'(RSP_DEPTH));
  assign acc         = req_valid_i & req_ready_o;

  // SRAM drive is a pure passthrough. Only the strobe is qualified, and
  // req_ready_o is already low during reset.
  assign sram_req_o   = acc;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a value on every path, starting with
  // the defaults at the top; a missed path would infer a latch.
  always_comb begin
    inflight_d = acc & ~req_we_i;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // When push and pop happen together, the occupancy stays the same.
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the value from before the edge, whatever the statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Data still in flight and buffered data are dropped. Because
      // inflight is cleared, the next cycle does not push the late SRAM
      // read data.
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Occupancy and pointers decide
  // whether an entry is valid, so clearing the data would only cost
  // reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= sram_rdata_i;
    end
  end

endmodule

// File: tb/tb_sram_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_sram_stream_adapter
//
// Two adapters (RSP_DEPTH = 2 and 3) share one stimulus stream. Each has its
// own SRAM model and its own reference model. The reference keeps a memory
// image and a queue of owed responses. Each response carries the cycle in
// which it becomes visible (accept cycle + 2). Each negedge, the outputs are
// compared against what that queue implies. Directed sequences add literal
// expectations on the RSP_DEPTH=2 instance.
// -----------------------------------------------------------------------------
module tb_sram_stream_adapter;

  localparam int DW = 64;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int NB = 8;

  typedef struct {
    logic [DW-1:0] data;
    int            vis;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;
  logic          rsp_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? 2 : 3;

    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [NB-1:0] sram_be;
    logic [DW-1:0] sram_rdata;

    logic [DW-1:0] smem    [NW];
    logic [DW-1:0] ref_mem [NW];
    rsp_t          q[$];
    int            cyc_n = 0;

    sram_stream_adapter #(
      .DATA_WIDTH(DW),
      .NUM_WORDS (NW),
      .RSP_DEPTH (D)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_be_i    (req_be),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .sram_req_o  (sram_req),
      .sram_we_o   (sram_we),
      .sram_addr_o (sram_addr),
      .sram_wdata_o(sram_wdata),
      .sram_be_o   (sram_be),
      .sram_rdata_i(sram_rdata)
    );

    // SRAM macro: byte-enable write, registered read data, 1-cycle latency.
    always @(posedge clk) begin
      if (sram_req) begin
        if (sram_we) begin
          for (int b = 0; b < NB; b++) begin
            if (sram_be[b]) smem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
          end
        end else begin
          sram_rdata <= smem[sram_addr];
        end
      end
    end

    // Reference model and compare, one step per cycle.
    always @(negedge clk) begin
      logic ev;
      logic er;
      logic pop;
      logic acc;
      int   owed;
      rsp_t e;

      ev = 1'b0;
      if (!rst && q.size() != 0) ev = (q[0].vis <= cyc_n);
      check($sformatf("i%0d rsp_valid c%0d", g, cyc_n), DW'(rsp_valid), DW'(ev));
      if (ev) check($sformatf("i%0d rsp_rdata c%0d", g, cyc_n), rsp_rdata, q[0].data);

      pop  = ev && rsp_ready;
      owed = q.size() - (pop ? 1 : 0);
      er   = !rst && (owed < D);
      check($sformatf("i%0d req_ready c%0d", g, cyc_n), DW'(req_ready), DW'(er));

      acc = req_valid && er;
      check($sformatf("i%0d sram_req c%0d", g, cyc_n), DW'(sram_req), DW'(acc));
      if (acc) begin
        check($sformatf("i%0d sram_we c%0d", g, cyc_n), DW'(sram_we), DW'(req_we));
        check($sformatf("i%0d sram_addr c%0d", g, cyc_n), DW'(sram_addr), DW'(req_addr));
        check($sformatf("i%0d sram_wdata c%0d", g, cyc_n), sram_wdata, req_wdata);
        check($sformatf("i%0d sram_be c%0d", g, cyc_n), DW'(sram_be), DW'(req_be));
      end

      if (rst) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          if (req_we) begin
            for (int b = 0; b < NB; b++) begin
              if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
            end
          end else begin
            e.data = ref_mem[req_addr];
            e.vis  = cyc_n + 2;
            q.push_back(e);
          end
        end
      end
      cyc_n++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;

    // Prefill every word so later reads have known contents: word a holds
    // byte value (a+1) in every lane.
    for (int a = 0; a < NW; a++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = AW'(a);
      req_wdata = 64'h0101_0101_0101_0101 * DW'(a + 1);
      req_be    = '1;
      cyc();
    end

    // Full write, then read the same word in the next cycle.
    req_we = 1'b1; req_addr = 4'd5; req_wdata = 64'h1122_3344_5566_7788; req_be = 8'hFF;
    cyc();
    req_we = 1'b0;
    @(negedge clk) check("t1 ready on read", DW'(g_inst[0].req_ready), DW'(1));
    cyc(); req_valid = 1'b0;
    @(negedge clk) check("t1 valid at N+1", DW'(g_inst[0].rsp_valid), DW'(0));
    cyc();
    @(negedge clk) begin
      check("t1 valid at N+2", DW'(g_inst[0].rsp_valid), DW'(1));
      check("t1 rdata", g_inst[0].rsp_rdata, 64'h1122_3344_5566_7788);
    end
    cyc();
    @(negedge clk) check("t1 valid after pop", DW'(g_inst[0].rsp_valid), DW'(0));

    // Partial write over the low four bytes, then read back.
    cyc();
    req_valid = 1'b1; req_we = 1'b1; req_be = 8'h0F; req_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
    cyc(); req_we = 1'b0; req_be = 8'hFF;
    cyc(); req_valid = 1'b0;
    cyc();
    @(negedge clk) begin
      check("t2 valid", DW'(g_inst[0].rsp_valid), DW'(1));
      check("t2 rdata", g_inst[0].rsp_rdata, 64'h1122_3344_AAAA_AAAA);
    end

    // Back-to-back reads with the consumer always ready.
    cyc();
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(i);
      @(negedge clk) check($sformatf("t3 ready read %0d", i), DW'(g_inst[0].req_ready), DW'(1));
      cyc();
    end
    req_valid = 1'b0;
    repeat (3) cyc();

    // Stalled consumer: two reads fit, the third waits.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'd0;
    @(negedge clk) check("t4 ready c0", DW'(g_inst[0].req_ready), DW'(1));
    cyc(); req_addr = 4'd1;
    @(negedge clk) check("t4 ready c1", DW'(g_inst[0].req_ready), DW'(1));
    cyc(); req_addr = 4'd2;
    @(negedge clk) check("t4 ready c2", DW'(g_inst[0].req_ready), DW'(0));
    cyc();
    @(negedge clk) begin
      check("t4 ready c3", DW'(g_inst[0].req_ready), DW'(0));
      check("t4 head stable", g_inst[0].rsp_rdata, 64'h0101_0101_0101_0101);
    end
    cyc(); rsp_ready = 1'b1;
    @(negedge clk) begin
      check("t4 head @0", g_inst[0].rsp_rdata, 64'h0101_0101_0101_0101);
      check("t4 ready on pop", DW'(g_inst[0].req_ready), DW'(1));
    end
    cyc(); req_valid = 1'b0;
    @(negedge clk) check("t4 head @1", g_inst[0].rsp_rdata, 64'h0202_0202_0202_0202);
    cyc();
    @(negedge clk) check("t4 head @2", g_inst[0].rsp_rdata, 64'h0303_0303_0303_0303);
    repeat (3) cyc();

    // Reset while one read is buffered and one is in flight.
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
    cyc(); req_addr = 4'd1;
    cyc(); rst = 1'b1; req_addr = 4'd3;
    @(negedge clk) begin
      check("t5 sram_req in reset", DW'(g_inst[0].sram_req), DW'(0));
      check("t5 ready in reset", DW'(g_inst[0].req_ready), DW'(0));
      check("t5 valid in reset", DW'(g_inst[0].rsp_valid), DW'(0));
    end
    cyc(); rst = 1'b0; req_valid = 1'b0;
    @(negedge clk) check("t5 valid after reset", DW'(g_inst[0].rsp_valid), DW'(0));
    cyc();
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D; req_be = '1;
    cyc(); req_we = 1'b0;
    cyc(); req_valid = 1'b0;
    @(negedge clk) check("t5 valid at N+1", DW'(g_inst[0].rsp_valid), DW'(0));
    cyc();
    @(negedge clk) begin
      check("t5 valid at N+2", DW'(g_inst[0].rsp_valid), DW'(1));
      check("t5 rdata own", g_inst[0].rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    end
    cyc();
    @(negedge clk) check("t5 no extra rsp", DW'(g_inst[0].rsp_valid), DW'(0));

    // Random traffic, with periodic consumer stalls and rare resets.
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 2) == 0);
      req_addr  = AW'($urandom_range(0, NW - 1));
      req_wdata = {$urandom, $urandom};
      req_be    = NB'($urandom);
      if ((n % 200) < 20) rsp_ready = 1'b0;
      else                rsp_ready = ($urandom_range(0, 3) != 0);
    end
    cyc();
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
